// File: rtl/branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolver
// Brief    : Execute-stage branch resolution. Latches NZVC from compares,
//            evaluates conditional branches against the latched flags,
//            drives the PC redirect, runs the wrong-path squash window and
//            keeps saturating branch statistics.
// Revision : 1.0  initial release
// ============================================================================
module branch_resolver #(
  parameter int OPCODEWIDTH  = 4,
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2,   // squash length after a taken branch, 1..15
  parameter int CNTWIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   validE,
  input  logic                   stallE,
  input  logic [OPCODEWIDTH-1:0] opcodeE,
  input  logic                   N,
  input  logic                   Z,
  input  logic                   V,
  input  logic                   C,
  input  logic [WIDTH-1:0]       targetE,
  output logic                   takeBranchE,
  output logic                   pcRedirectValidF,
  output logic [WIDTH-1:0]       pcRedirectF,
  output logic                   flushFD,
  output logic                   flushDE,
  output logic                   squashing,
  output logic [3:0]             flagsOut,
  output logic [CNTWIDTH-1:0]    branchCount,
  output logic [CNTWIDTH-1:0]    takenCount
);

  // FSM encoding
  localparam logic [0:0] c_ST_RUN    = 1'b0;
  localparam logic [0:0] c_ST_SQUASH = 1'b1;

  // Squash window length, held in a 4-bit down-counter
  localparam logic [3:0] c_FLUSH = 4'(FLUSH_CYCLES);

  // Opcodes decoded by this block; everything else is ignored
  localparam logic [OPCODEWIDTH-1:0] c_OP_CMP = OPCODEWIDTH'(4'b1010);
  localparam logic [OPCODEWIDTH-1:0] c_OP_B   = OPCODEWIDTH'(4'b1011);
  localparam logic [OPCODEWIDTH-1:0] c_OP_BEQ = OPCODEWIDTH'(4'b1100);
  localparam logic [OPCODEWIDTH-1:0] c_OP_BNE = OPCODEWIDTH'(4'b1101);
  localparam logic [OPCODEWIDTH-1:0] c_OP_BLT = OPCODEWIDTH'(4'b1110);
  localparam logic [OPCODEWIDTH-1:0] c_OP_BGT = OPCODEWIDTH'(4'b1111);

  localparam logic [CNTWIDTH-1:0] c_CNT_ONE = CNTWIDTH'(1);

  logic [0:0]          r_state;
  logic [0:0]          w_stateNext;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cntNext;
  logic [3:0]          r_flags;
  logic [CNTWIDTH-1:0] r_branchCount;
  logic [CNTWIDTH-1:0] r_takenCount;

  logic w_active;
  logic w_isBranch;
  logic w_cond;
  logic w_take;
  logic w_squash;

  // Only an unstalled valid instruction seen while in RUN has any effect.
  assign w_active = validE & ~stallE & (r_state == c_ST_RUN);

  // Decode branch opcodes and evaluate their condition against latched flags
  // (flag layout {N,Z,V,C}); the live ALU flags never steer a branch.
  always_comb begin
    w_isBranch = 1'b0;
    w_cond     = 1'b0;
    case (opcodeE)
      c_OP_B: begin
        w_isBranch = 1'b1;
        w_cond     = 1'b1;
      end
      c_OP_BEQ: begin
        w_isBranch = 1'b1;
        w_cond     = r_flags[2];
      end
      c_OP_BNE: begin
        w_isBranch = 1'b1;
        w_cond     = ~r_flags[2];
      end
      c_OP_BLT: begin
        w_isBranch = 1'b1;
        w_cond     = r_flags[3] ^ r_flags[1];
      end
      c_OP_BGT: begin
        w_isBranch = 1'b1;
        w_cond     = ~r_flags[2] & ~(r_flags[3] ^ r_flags[1]);
      end
      default: begin
        w_isBranch = 1'b0;
        w_cond     = 1'b0;
      end
    endcase
  end

  assign w_take = w_active & w_isBranch & w_cond;

  // State register: FSM state and remaining squash cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Next-state logic: a taken branch opens the window; unstalled cycles
  // drain it, stalled cycles hold it so the squash covers the same slots.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      c_ST_RUN: begin
        if (w_take) begin
          w_stateNext = c_ST_SQUASH;
          w_cntNext   = c_FLUSH;
        end
      end
      c_ST_SQUASH: begin
        if (!stallE) begin
          w_cntNext = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_stateNext = c_ST_RUN;
          end
        end
      end
      default: begin
        w_stateNext = c_ST_RUN;
        w_cntNext   = 4'd0;
      end
    endcase
  end

  // Output logic: redirect in the resolving cycle, flush during the whole window
  always_comb begin
    w_squash         = (r_state == c_ST_SQUASH);
    takeBranchE      = w_take;
    pcRedirectValidF = w_take;
    pcRedirectF      = w_take ? targetE : '0;
    squashing        = w_squash;
    flushFD          = w_take | w_squash;
    flushDE          = w_take | w_squash;
  end

  // Flag latch: only an active compare writes the flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags <= 4'd0;
    end else if (w_active && (opcodeE == c_OP_CMP)) begin
      r_flags <= {N, Z, V, C};
    end
  end

  // Saturating statistics: evaluated branches and taken branches
  always_ff @(posedge clk) begin
    if (reset) begin
      r_branchCount <= '0;
      r_takenCount  <= '0;
    end else begin
      if (w_active && w_isBranch && !(&r_branchCount)) begin
        r_branchCount <= r_branchCount + c_CNT_ONE;
      end
      if (w_take && !(&r_takenCount)) begin
        r_takenCount <= r_takenCount + c_CNT_ONE;
      end
    end
  end

  assign flagsOut    = r_flags;
  assign branchCount = r_branchCount;
  assign takenCount  = r_takenCount;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolver
// Brief    : Directed self-checking bench for branch_resolver. A second
//            instance with 2-bit counters exercises statistic saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_resolver;

  localparam int FLUSH = 2;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_B   = 4'b1011;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;
  localparam logic [3:0] OP_BLT = 4'b1110;
  localparam logic [3:0] OP_BGT = 4'b1111;

  logic        clk;
  logic        reset;
  logic        validE;
  logic        stallE;
  logic [3:0]  opcodeE;
  logic        N, Z, V, C;
  logic [31:0] targetE;

  logic        takeBranchE, pcRedirectValidF, flushFD, flushDE, squashing;
  logic [31:0] pcRedirectF;
  logic [3:0]  flagsOut;
  logic [15:0] branchCount, takenCount;

  logic        s_take, s_prv, s_ffd, s_fde, s_sq;
  logic [31:0] s_pc;
  logic [3:0]  s_flags;
  logic [1:0]  s_bc, s_tc;

  int n_vec = 0;
  int n_err = 0;

  branch_resolver #(.OPCODEWIDTH(4), .WIDTH(32), .FLUSH_CYCLES(FLUSH), .CNTWIDTH(16)) u_dut (
    .clk(clk), .reset(reset), .validE(validE), .stallE(stallE), .opcodeE(opcodeE),
    .N(N), .Z(Z), .V(V), .C(C), .targetE(targetE),
    .takeBranchE(takeBranchE), .pcRedirectValidF(pcRedirectValidF), .pcRedirectF(pcRedirectF),
    .flushFD(flushFD), .flushDE(flushDE), .squashing(squashing), .flagsOut(flagsOut),
    .branchCount(branchCount), .takenCount(takenCount)
  );

  branch_resolver #(.OPCODEWIDTH(4), .WIDTH(32), .FLUSH_CYCLES(FLUSH), .CNTWIDTH(2)) u_sat (
    .clk(clk), .reset(reset), .validE(validE), .stallE(stallE), .opcodeE(opcodeE),
    .N(N), .Z(Z), .V(V), .C(C), .targetE(targetE),
    .takeBranchE(s_take), .pcRedirectValidF(s_prv), .pcRedirectF(s_pc),
    .flushFD(s_ffd), .flushDE(s_fde), .squashing(s_sq), .flagsOut(s_flags),
    .branchCount(s_bc), .takenCount(s_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Branch condition from the architectural rules; f = {N,Z,V,C}
  function automatic logic taken_by_rule(input logic [3:0] f, input logic [3:0] op);
    case (op)
      OP_B:    return 1'b1;
      OP_BEQ:  return f[2];
      OP_BNE:  return !f[2];
      OP_BLT:  return f[3] != f[1];
      OP_BGT:  return !f[2] && (f[3] == f[1]);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat_inc(input int x, input int maxv);
    return (x >= maxv) ? maxv : x + 1;
  endfunction

  // Reference model: architectural flags, squash slots left, branch totals
  logic [3:0] m_flags = 4'd0;
  int         m_left  = 0;
  int         m_bc = 0, m_tc = 0, m_bc2 = 0, m_tc2 = 0;
  bit         m_known = 1'b0;

  // Compare every cycle against the model, then advance the model
  always @(negedge clk) begin : p_model
    logic act, br, tk;
    act = validE && !stallE && (m_left == 0);
    br  = (opcodeE >= OP_B);
    tk  = act && br && taken_by_rule(m_flags, opcodeE);
    if (m_known) begin
      chk("takeBranchE", {31'd0, takeBranchE}, {31'd0, tk});
      chk("pcRedirectValidF", {31'd0, pcRedirectValidF}, {31'd0, tk});
      chk("pcRedirectF", pcRedirectF, tk ? targetE : 32'd0);
      chk("flushFD", {31'd0, flushFD}, {31'd0, tk || (m_left > 0)});
      chk("flushDE", {31'd0, flushDE}, {31'd0, tk || (m_left > 0)});
      chk("squashing", {31'd0, squashing}, {31'd0, m_left > 0});
      chk("flagsOut", {28'd0, flagsOut}, {28'd0, m_flags});
      chk("branchCount", {16'd0, branchCount}, m_bc);
      chk("takenCount", {16'd0, takenCount}, m_tc);
      chk("sat.takeBranchE", {31'd0, s_take}, {31'd0, tk});
      chk("sat.branchCount", {30'd0, s_bc}, m_bc2);
      chk("sat.takenCount", {30'd0, s_tc}, m_tc2);
    end
    if (reset) begin
      m_flags = 4'd0; m_left = 0;
      m_bc = 0; m_tc = 0; m_bc2 = 0; m_tc2 = 0;
      m_known = 1'b1;
    end else begin
      if (act && opcodeE == OP_CMP) m_flags = {N, Z, V, C};
      if (act && br) begin
        m_bc  = sat_inc(m_bc, 65535);
        m_bc2 = sat_inc(m_bc2, 3);
      end
      if (tk) begin
        m_tc   = sat_inc(m_tc, 65535);
        m_tc2  = sat_inc(m_tc2, 3);
        m_left = FLUSH;
      end else if (m_left > 0 && !stallE) begin
        m_left = m_left - 1;
      end
    end
  end

  // One clock cycle of stimulus; returns mid-cycle so callers can check
  task automatic cyc(input logic r, input logic v, input logic s,
                     input logic [3:0] op, input logic [3:0] f, input logic [31:0] t);
    @(posedge clk); #1;
    reset = r; validE = v; stallE = s; opcodeE = op;
    {N, Z, V, C} = f; targetE = t;
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, OP_NOP, 4'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; validE = 1'b0; stallE = 1'b0; opcodeE = 4'd0;
    N = 1'b0; Z = 1'b0; V = 1'b0; C = 1'b0; targetE = 32'd0;

    // Reset state
    cyc(1, 0, 0, OP_NOP, 4'd0, 0);
    cyc(1, 0, 0, OP_NOP, 4'd0, 0);
    idle(1);
    chk("reset.flagsOut", {28'd0, flagsOut}, 32'd0);
    chk("reset.squashing", {31'd0, squashing}, 32'd0);
    chk("reset.branchCount", {16'd0, branchCount}, 32'd0);
    chk("reset.pcRedirectF", pcRedirectF, 32'd0);

    // Compare Z=1,C=1 then BEQ: taken, two squash cycles
    cyc(0, 1, 0, OP_CMP, 4'b0101, 0);
    cyc(0, 1, 0, OP_BEQ, 4'b0000, 32'h40);
    chk("beq.flagsOut", {28'd0, flagsOut}, 32'h5);
    chk("beq.take", {31'd0, takeBranchE}, 32'd1);
    chk("beq.pcRedirectF", pcRedirectF, 32'h40);
    chk("beq.flushFD", {31'd0, flushFD}, 32'd1);
    idle(1); chk("beq.sq1", {31'd0, squashing}, 32'd1);
    idle(1); chk("beq.sq2", {31'd0, squashing}, 32'd1);
    idle(1); chk("beq.sq3", {31'd0, squashing}, 32'd0);
    chk("beq.takenCount", {16'd0, takenCount}, 32'd1);
    chk("beq.branchCount", {16'd0, branchCount}, 32'd1);

    // Z=0: BEQ not taken, BNE taken
    cyc(0, 1, 0, OP_CMP, 4'b0000, 0);
    cyc(0, 1, 0, OP_BEQ, 4'b0100, 32'h80);
    chk("beq0.take", {31'd0, takeBranchE}, 32'd0);
    idle(1);
    chk("beq0.squashing", {31'd0, squashing}, 32'd0);
    chk("beq0.branchCount", {16'd0, branchCount}, 32'd2);
    chk("beq0.takenCount", {16'd0, takenCount}, 32'd1);
    cyc(0, 1, 0, OP_BNE, 4'b0100, 32'h84);
    chk("bne.take", {31'd0, takeBranchE}, 32'd1);
    chk("bne.pcRedirectF", pcRedirectF, 32'h84);
    idle(3);

    // N=1,V=0: BLT taken, BGT not; N=V=Z=0: BGT taken, BLT not
    cyc(0, 1, 0, OP_CMP, 4'b1000, 0);
    cyc(0, 1, 0, OP_BLT, 4'b0000, 32'h100);
    chk("blt.take", {31'd0, takeBranchE}, 32'd1);
    idle(3);
    cyc(0, 1, 0, OP_BGT, 4'b0000, 32'h104);
    chk("bgt.nt", {31'd0, takeBranchE}, 32'd0);
    cyc(0, 1, 0, OP_CMP, 4'b0000, 0);
    cyc(0, 1, 0, OP_BGT, 4'b1010, 32'h108);
    chk("bgt.take", {31'd0, takeBranchE}, 32'd1);
    idle(3);
    cyc(0, 1, 0, OP_BLT, 4'b0000, 32'h10c);
    chk("blt.nt", {31'd0, takeBranchE}, 32'd0);
    idle(1);
    chk("cond.branchCount", {16'd0, branchCount}, 32'd7);
    chk("cond.takenCount", {16'd0, takenCount}, 32'd4);

    // Ignored opcodes and an invalid branch leave everything alone
    cyc(0, 1, 0, 4'b0011, 4'b1111, 32'h5);
    cyc(0, 1, 0, 4'b1001, 4'b1111, 32'h6);
    cyc(0, 0, 0, OP_B, 4'b1111, 32'h7);
    chk("invalid.take", {31'd0, takeBranchE}, 32'd0);

    // Inputs during a stalled squash window are ignored; window stretches
    cyc(0, 1, 0, OP_B, 4'b0000, 32'h200);
    chk("sqw.take", {31'd0, takeBranchE}, 32'd1);
    cyc(0, 1, 0, OP_CMP, 4'b1111, 0);
    chk("sqw.cmp.sq", {31'd0, squashing}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, OP_B, 4'b1111, 32'h204);
      chk("sqw.stall.sq", {31'd0, squashing}, 32'd1);
      chk("sqw.stall.take", {31'd0, takeBranchE}, 32'd0);
    end
    cyc(0, 1, 0, OP_B, 4'b1111, 32'h208);
    chk("sqw.last.sq", {31'd0, squashing}, 32'd1);
    chk("sqw.last.take", {31'd0, takeBranchE}, 32'd0);
    idle(1);
    chk("sqw.end.sq", {31'd0, squashing}, 32'd0);
    chk("sqw.flagsOut", {28'd0, flagsOut}, 32'd0);
    chk("sqw.takenCount", {16'd0, takenCount}, 32'd5);

    // Stalled branch is evaluated only once the stall drops
    cyc(1, 0, 0, OP_NOP, 4'd0, 0);
    idle(1);
    cyc(0, 1, 1, OP_B, 4'd0, 32'h300);
    chk("stall.take1", {31'd0, takeBranchE}, 32'd0);
    cyc(0, 1, 1, OP_B, 4'd0, 32'h300);
    chk("stall.take2", {31'd0, takeBranchE}, 32'd0);
    cyc(0, 1, 0, OP_B, 4'd0, 32'h300);
    chk("stall.take3", {31'd0, takeBranchE}, 32'd1);
    chk("stall.pcRedirectF", pcRedirectF, 32'h300);
    idle(1);
    chk("stall.branchCount", {16'd0, branchCount}, 32'd1);
    idle(2);

    // Reset in the first squash cycle clears everything
    cyc(0, 1, 0, OP_CMP, 4'b1010, 0);
    cyc(0, 1, 0, OP_B, 4'd0, 32'h400);
    cyc(1, 0, 0, OP_NOP, 4'd0, 0);
    idle(1);
    chk("rst.squashing", {31'd0, squashing}, 32'd0);
    chk("rst.flushFD", {31'd0, flushFD}, 32'd0);
    chk("rst.flagsOut", {28'd0, flagsOut}, 32'd0);
    chk("rst.branchCount", {16'd0, branchCount}, 32'd0);
    chk("rst.takenCount", {16'd0, takenCount}, 32'd0);

    // Five taken branches: 2-bit counters pin at 3, 16-bit reach 5
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, OP_B, 4'd0, 32'h500 + i);
      idle(2);
    end
    idle(1);
    chk("sat.bc3", {30'd0, s_bc}, 32'd3);
    chk("sat.tc3", {30'd0, s_tc}, 32'd3);
    chk("wide.bc5", {16'd0, branchCount}, 32'd5);
    chk("wide.tc5", {16'd0, takenCount}, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage branch resolution unit for the pipelined processor. It is the consumer of the decoder's branch-path controls. It latches the NZVC flags produced by compare instructions, evaluates the conditional branch opcodes against those latched flags, and drives the PC redirect. It then runs a squash window that invalidates wrong-path instructions in fetch/decode and suppresses their effects in execute. It also keeps saturating branch statistics.

## Interface
- OPCODEWIDTH, 4, opcode width; must match decode.
- WIDTH, 32, PC/branch-target width.
- FLUSH_CYCLES, 2, number of squash cycles after a taken branch; legal range 1..15.
- CNTWIDTH, 16, statistics counter width.

Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- validE  in  1  execute-stage instruction is valid.
- stallE  in  1  execute stage held this cycle.
- opcodeE  in  OPCODEWIDTH  opcode of the execute-stage instruction.
- N, Z, V, C  in  1 each  ALU flags for the execute-stage instruction.
- targetE  in  WIDTH  branch target computed by the ALU (PC-relative).
- takeBranchE  out  1  branch taken this cycle (combinational).
- pcRedirectValidF  out  1  fetch must load pcRedirectF (combinational, equal to takeBranchE).
- pcRedirectF  out  WIDTH  redirect address; equals targetE when valid, 0 otherwise.
- flushFD  out  1  clear the fetch/decode pipeline register.
- flushDE  out  1  clear the decode/execute pipeline register.
- squashing  out  1  FSM is in SQUASH.
- flagsOut  out  4  registered {N,Z,V,C}.
- branchCount  out  CNTWIDTH  branches evaluated.
- takenCount  out  CNTWIDTH  branches taken.

## Operation
- An instruction is "active" when validE=1, stallE=0 and the state is RUN. No other instruction has any effect.
- Compare (opcode 1010), when active: flagsOut <= {N,Z,V,C} at the clock edge. No other opcode writes the flags.
- Branch opcodes are evaluated against flagsOut, never against the live N/Z/V/C inputs:
  - 1011: always taken.
  - 1100: taken if Z.
  - 1101: taken if !Z.
  - 1110: taken if N!=V.
  - 1111: taken if !Z && N==V.
- Opcodes 0000–1001 are ignored by this block.
- FSM:
  - RUN is the reset state.
  - RUN -> SQUASH when an active branch is taken; cnt <= FLUSH_CYCLES.
  - In SQUASH, cnt decrements on each cycle with stallE=0; cnt holds while stallE=1.
  - SQUASH -> RUN on the edge where cnt==1 and stallE=0.
- While in SQUASH, execute-stage inputs are ignored: no flag write, no branch evaluation, no counter updates.
- flushFD and flushDE are asserted in the cycle a branch is taken and during every SQUASH cycle.
- Statistics:
  - branchCount increments on every active branch opcode.
  - takenCount increments on every taken branch.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset values:
  - State RUN, cnt 0.
  - flagsOut 0.
  - branchCount 0, takenCount 0.
  - takeBranchE, pcRedirectValidF, flushFD, flushDE and squashing are 0.
  - pcRedirectF is 0.
- Branch resolution has zero-cycle latency. takeBranchE, pcRedirectValidF, pcRedirectF, flushFD and flushDE are valid in the same cycle T as the branch in execute.
- squashing=1 from cycle T+1 through T+FLUSH_CYCLES when there are no stalls. Stall cycles extend the window one-for-one.
- Compare immediately followed by a branch: the compare is in E at cycle T and writes the flags at the edge ending T. The branch in E at T+1 uses the new flags, so no bypass is needed.
- Compare with stallE=1 in RUN: no flag write in that cycle. The write happens in the cycle the stall drops.
- Branch with stallE=1 in RUN: not evaluated. takeBranchE=0, no counters change, and evaluation happens in the first unstalled cycle.
- Reset asserted mid-SQUASH: all state returns to reset values at that edge, and outputs are deasserted from the next cycle.
- A taken branch is the only path into SQUASH. A new branch arriving during SQUASH is squashed, not queued.

## Test plan
- Reset, then compare with N=0,Z=1,V=0,C=1 active -> flagsOut=4'b0101 after one edge; BEQ (1100) next cycle with targetE=0x40 -> takeBranchE=1, pcRedirectF=0x40, flushFD=flushDE=1 that cycle; squashing=1 for exactly 2 cycles; takenCount=1, branchCount=1.
- Flags Z=0, BEQ -> takeBranchE=0, no squash, branchCount increments, takenCount unchanged; BNE with same flags -> taken.
- Flags N=1,V=0 -> BLT (1110) taken, BGT (1111) not taken; flags N=0,V=0,Z=0 -> BGT taken, BLT not taken.
- Taken branch with FLUSH_CYCLES=2; in cycle T+1 present a valid compare with new flags and a valid branch 1011, then hold stallE=1 for 3 cycles -> flagsOut unchanged, no second redirect, squashing stays high for 2 unstalled cycles (5 cycles total).
- Branch 1011 with stallE=1 for 2 cycles -> takeBranchE=0 throughout; stallE drops -> taken in that cycle; branchCount=1.
- Reset asserted at T+1 of a squash -> next cycle squashing=0, flagsOut=0, counters 0; CNTWIDTH=2 with 5 taken branches -> both counters hold at 3.
